// File: rtl/qsystd_niosii_cpu_debug_jtag_host.sv
// Virtual-JTAG initiator for the Nios II debug slave: turns (IR, DR) commands into tck/tdi and vji_* strobes.
// Optional IR cache enabled by defining QSYSTD_DBG_JTAG_IR_CACHE_EN (skips UIR when the IR is unchanged).
// state | meaning: IDLE ready for command, UIR update-IR, CDR capture-DR, SDR shift-DR, UDR update-DR, RSP result held
module qsystd_niosii_cpu_debug_jtag_host #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [SR_WIDTH-1:0] cmd_dr_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [SR_WIDTH-1:0] rsp_dr_o,
  output logic [IR_WIDTH-1:0] rsp_ir_out_o,
  output logic                vji_tck_o,
  output logic                vji_tdi_o,
  input  logic                vji_tdo_i,
  output logic [IR_WIDTH-1:0] vji_ir_in_o,
  input  logic [IR_WIDTH-1:0] vji_ir_out_i,
  output logic                vji_rti_o,
  output logic                vji_uir_o,
  output logic                vji_cdr_o,
  output logic                vji_sdr_o,
  output logic                vji_udr_o
);

  localparam int DIV_W = $clog2(2 * TCK_DIV);
  localparam int BIT_W = $clog2(SR_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tck_q, tck_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SR_WIDTH-1:0] sh_q, sh_d;
  logic [SR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
  logic [IR_WIDTH-1:0] cache_q, cache_d;
  logic                cache_vld_q, cache_vld_d;
`endif
  logic                scan;
  logic                tck_rise;
  logic                period_end;

  assign scan       = (state_q == ST_UIR) || (state_q == ST_CDR) ||
                      (state_q == ST_SDR) || (state_q == ST_UDR);
  assign tck_rise   = scan && (div_q == DIV_W'(TCK_DIV - 1));
  assign period_end = scan && (div_q == DIV_W'(2 * TCK_DIV - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      tck_q       <= 1'b0;
      bit_q       <= '0;
      sh_q        <= '0;
      rsp_dr_q    <= '0;
      ir_out_q    <= '0;
      ir_q        <= '0;
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rsp_dr_q    <= rsp_dr_d;
      ir_out_q    <= ir_out_d;
      ir_q        <= ir_d;
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tck_d       = tck_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rsp_dr_d    = rsp_dr_q;
    ir_out_d    = ir_out_q;
    ir_d        = ir_q;
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
`endif
    // Divider wraps at every period end, so it is already zero whenever a scan state is left.
    if (scan) begin
      if (period_end) begin
        div_d = '0;
        tck_d = 1'b0;
      end else begin
        div_d = div_q + 1'b1;
        if (tck_rise) tck_d = 1'b1;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          ir_d    = cmd_ir_i;
          sh_d    = cmd_dr_i;
          state_d = ST_UIR;
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
          if (cache_vld_q && (cmd_ir_i == cache_q)) state_d = ST_CDR;
`endif
        end
      end
      ST_UIR: begin
        if (period_end) begin
          state_d = ST_CDR;
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
          cache_d     = ir_q;
          cache_vld_d = 1'b1;
`endif
        end
      end
      ST_CDR: begin
        if (tck_rise) ir_out_d = vji_ir_out_i;
        if (period_end) begin
          state_d = ST_SDR;
          bit_d   = '0;
        end
      end
      ST_SDR: begin
        if (tck_rise) rsp_dr_d = {vji_tdo_i, rsp_dr_q[SR_WIDTH-1:1]};
        if (period_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == BIT_W'(SR_WIDTH - 1)) state_d = ST_UDR;
          else                               bit_d   = bit_q + 1'b1;
        end
      end
      ST_UDR: begin
        if (period_end) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign rsp_valid_o  = (state_q == ST_RSP);
  assign rsp_dr_o     = rsp_dr_q;
  assign rsp_ir_out_o = ir_out_q;
  assign vji_tck_o    = tck_q;
  assign vji_tdi_o    = (state_q == ST_SDR) & sh_q[0];
  assign vji_ir_in_o  = ir_q;
  assign vji_rti_o    = (state_q == ST_IDLE) || (state_q == ST_RSP);
  assign vji_uir_o    = (state_q == ST_UIR);
  assign vji_cdr_o    = (state_q == ST_CDR);
  assign vji_sdr_o    = (state_q == ST_SDR);
  assign vji_udr_o    = (state_q == ST_UDR);

endmodule

// File: tb/tb_qsystd_niosii_cpu_debug_jtag_host.sv
// Bench for qsystd_niosii_cpu_debug_jtag_host: command table, scoreboard of expected responses,
// strobe/latency accounting, backpressure, IR cache (QSYSTD_DBG_JTAG_IR_CACHE_EN) and mid-scan reset.
module tb_qsystd_niosii_cpu_debug_jtag_host;
  localparam int SR  = 38;
  localparam int IRW = 2;
  localparam int DIV = 2;
  localparam int PER = 2 * DIV;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [SR-1:0]  cmd_dr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [SR-1:0]  rsp_dr;
  logic [IRW-1:0] rsp_ir_out;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [IRW-1:0] vji_ir_in;
  logic [IRW-1:0] vji_ir_out = '0;
  logic           vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

  int errors = 0;
  int checks = 0;

  // slave model: 0 = loopback (tdi delayed one tck), 1 = tdo stuck 1, 2 = tdo stuck 0
  int   tdo_mode = 0;
  logic loop_q;
  always @(posedge vji_tck or negedge reset_n)
    if (!reset_n) loop_q <= 1'b0;
    else          loop_q <= vji_tdi;
  assign vji_tdo = (tdo_mode == 0) ? loop_q : (tdo_mode == 1);

  always #5 clk = ~clk;

  qsystd_niosii_cpu_debug_jtag_host #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_ir_i(cmd_ir), .cmd_dr_i(cmd_dr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dr_o(rsp_dr), .rsp_ir_out_o(rsp_ir_out),
    .vji_tck_o(vji_tck), .vji_tdi_o(vji_tdi), .vji_tdo_i(vji_tdo),
    .vji_ir_in_o(vji_ir_in), .vji_ir_out_i(vji_ir_out), .vji_rti_o(vji_rti),
    .vji_uir_o(vji_uir), .vji_cdr_o(vji_cdr), .vji_sdr_o(vji_sdr), .vji_udr_o(vji_udr)
  );

  typedef struct {
    logic [SR-1:0]  dr;
    logic [IRW-1:0] irout;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [IRW-1:0] ir;
    logic [SR-1:0]  dr;
    int             mode;
    logic [IRW-1:0] irout;
    logic [SR-1:0]  exp_dr;
    logic [IRW-1:0] exp_irout;
  } vec_t;
  vec_t vecs[5];

`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
  logic           mc_vld = 1'b0;
  logic [IRW-1:0] mc_ir = '0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_dr"}, 64'(rsp_dr), 64'd0);
    chk({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
    chk({tag, "_tck_tdi"}, 64'({vji_tck, vji_tdi}), 64'd0);
    chk({tag, "_ir_in"}, 64'(vji_ir_in), 64'd0);
    chk({tag, "_rti"}, 64'(vji_rti), 64'd1);
    chk({tag, "_strobes"}, 64'({vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'd0);
  endtask

  task automatic lat_model(input logic [IRW-1:0] ir, output int lat, output int uirn);
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
    if (mc_vld && ir == mc_ir) begin
      lat  = (2 + SR) * PER;
      uirn = 0;
    end else begin
      lat    = (3 + SR) * PER;
      uirn   = PER;
      mc_vld = 1'b1;
      mc_ir  = ir;
    end
`else
    lat  = (3 + SR) * PER;
    uirn = PER;
`endif
  endtask

  // Returns #1 after the accepting clock edge.
  task automatic accept(input logic [IRW-1:0] ir, input logic [SR-1:0] dr, input int mode,
                        input logic [IRW-1:0] irout, input logic [SR-1:0] edr,
                        input logic [IRW-1:0] eirout, input bit push);
    int w = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr; tdo_mode = mode; vji_ir_out = irout;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = ~dr;
    if (push) begin
      e.dr = edr; e.irout = eirout;
      exp_q.push_back(e);
    end
    chk("ir_in", 64'(vji_ir_in), 64'(ir));
  endtask

  // Starts #1 after the accept edge; ends #1 after the edge that raises rsp_valid.
  task automatic scan_check(input int lat, input int uirn);
    int n = 0, cu = 0, cc = 0, cs = 0, cd = 0, th = 0, bad = 0;
    while (!rsp_valid && n < 1000) begin
      cu += int'(vji_uir); cc += int'(vji_cdr); cs += int'(vji_sdr); cd += int'(vji_udr);
      th += int'(vji_tck);
      if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr}) != 1 || vji_rti !== 1'b0 ||
          cmd_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("uir_len", 64'(cu), 64'(uirn));
    chk("cdr_len", 64'(cc), 64'(PER));
    chk("sdr_len", 64'(cs), 64'(SR * PER));
    chk("udr_len", 64'(cd), 64'(PER));
    chk("tck_high", 64'(th), 64'(lat / 2));
    chk("onehot_rti_ready", 64'(bad), 64'd0);
    chk("rti_in_rsp", 64'(vji_rti), 64'd1);
  endtask

  task automatic take_rsp();
    int w = 0;
    exp_t e;
    @(negedge clk);
    while (!rsp_valid && w < 1000) begin @(negedge clk); w++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    end else begin
      rsp_ready = 1'b1;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_dr", 64'(rsp_dr), 64'(e.dr));
        chk("rsp_ir_out", 64'(rsp_ir_out), 64'(e.irout));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, uirn, bad;
    logic [SR-1:0] held;
    exp_t e;

    vecs[0] = '{2'b01, 38'h2A_5A5A_5A5A, 0, 2'b00, 38'h14_B4B4_B4B4, 2'b00};
    vecs[1] = '{2'b10, 38'h15_A5A5_A5A5, 1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10};
    vecs[2] = '{2'b11, 38'h00_0000_0000, 2, 2'b01, 38'h00_0000_0000, 2'b01};
    vecs[3] = '{2'b00, 38'h3F_FFFF_FFFF, 0, 2'b11, 38'h3F_FFFF_FFFE, 2'b11};
    vecs[4] = '{2'b01, 38'h01_2345_6789, 0, 2'b10, 38'h02_468A_CF12, 2'b10};

    #2;
    chk_reset("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      lat_model(vecs[i].ir, lat, uirn);
      accept(vecs[i].ir, vecs[i].dr, vecs[i].mode, vecs[i].irout,
             vecs[i].exp_dr, vecs[i].exp_irout, 1'b1);
      scan_check(lat, uirn);
      take_rsp();
    end

    // response backpressure with a new command already waiting
    lat_model(2'b10, lat, uirn);
    accept(2'b10, 38'h0F_0F0F_0F0F, 0, 2'b01, 38'h1E_1E1E_1E1E, 2'b01, 1'b1);
    scan_check(lat, uirn);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_dr = 38'h00_0000_0003; vji_ir_out = 2'b11;
    held = rsp_dr;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_dr !== held || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    take_rsp();
    chk("bp_ready_after", 64'({cmd_ready, rsp_valid}), 64'b10);
    tdo_mode = 1;
    lat_model(2'b01, lat, uirn);
    e.dr = 38'h3F_FFFF_FFFF; e.irout = 2'b11;
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("bp_accept", 64'(cmd_ready), 64'd0);
    chk("bp_ir_in", 64'(vji_ir_in), 64'd1);
    cmd_valid = 1'b0;
    scan_check(lat, uirn);
    take_rsp();

    // reset part way through the shift (bit 10)
    lat_model(2'b10, lat, uirn);
    accept(2'b10, 38'h2A_5A5A_5A5A, 1, 2'b10, '0, '0, 1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("abort_in_sdr", 64'(vji_sdr), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset("abort");
`ifdef QSYSTD_DBG_JTAG_IR_CACHE_EN
    mc_vld = 1'b0;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    chk("abort_no_rsp", 64'(bad), 64'd0);

    // repeated IR: with the cache the second command skips UIR
    lat_model(2'b11, lat, uirn);
    accept(2'b11, 38'h2A_5A5A_5A5A, 0, 2'b01, 38'h14_B4B4_B4B4, 2'b01, 1'b1);
    scan_check(lat, uirn);
    take_rsp();
    lat_model(2'b11, lat, uirn);
    accept(2'b11, 38'h15_A5A5_A5A5, 1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10, 1'b1);
    scan_check(lat, uirn);
    take_rsp();
    lat_model(2'b00, lat, uirn);
    accept(2'b00, 38'h00_FFFF_0000, 0, 2'b00, 38'h01_FFFE_0000, 2'b00, 1'b1);
    scan_check(lat, uirn);
    take_rsp();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
